// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude compare, MSB first, one bit pair per clock with early exit.
// Latency 1..WIDTH cycles after the accepting edge; start is ignored while busy (no queueing).

module comparator_1bit (
   input  logic a,
   input  logic b,
   output logic eq,
   output logic lt,
   output logic gt
);
   assign eq = ~(a ^ b);
   assign lt = ~a & b;
   assign gt = a & ~b;
endmodule

module serial_compare_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             lt,
   output logic             gt
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb, sa_nxt, sb_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             done_nxt, eq_nxt, lt_nxt, gt_nxt;
   logic             c_eq, c_lt, c_gt;

   comparator_1bit u_cell (
      .a  (sa[cnt]),
      .b  (sb[cnt]),
      .eq (c_eq),
      .lt (c_lt),
      .gt (c_gt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         eq    <= 1'b0;
         lt    <= 1'b0;
         gt    <= 1'b0;
      end else begin
         state <= state_nxt;
         sa    <= sa_nxt;
         sb    <= sb_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
         eq    <= eq_nxt;
         lt    <= lt_nxt;
         gt    <= gt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sa_nxt    = sa;
      sb_nxt    = sb;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      eq_nxt    = eq;
      lt_nxt    = lt;
      gt_nxt    = gt;
      case (state)
         IDLE: begin
            if (start) begin
               sa_nxt    = a;
               sb_nxt    = b;
               cnt_nxt   = CNT_MAX;
               eq_nxt    = 1'b0;
               lt_nxt    = 1'b0;
               gt_nxt    = 1'b0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // First differing bit from the MSB decides; equal bits just walk down.
            if (c_gt) begin
               gt_nxt    = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (c_lt) begin
               lt_nxt    = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == '0) begin
               eq_nxt    = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt   = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);

endmodule

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Sequencer that compares two WIDTH-bit unsigned operands using a single 1-bit compare cell (comparator_1bit: a, b -> eq, lt, gt). It processes one bit pair per clock, MSB first. It stops at the first differing bit and reports a one-hot eq/lt/gt result with a start/busy/done handshake. It sits between operand registers and control logic that needs magnitude compares but cannot afford a full parallel comparator.

## Interface
- WIDTH, 8: operand width in bits; legal range ≥2.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only while idle.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  compare in progress.
- done  output  1  single-cycle completion pulse.
- eq  output  1  A == B (valid from done onward).
- lt  output  1  A < B (valid from done onward).
- gt  output  1  A > B (valid from done onward).

## Operation
- State machine with two states.
  - IDLE: busy=0.
  - RUN: busy=1.
- Internal state: shift copies sa/sb (WIDTH bits each), bit counter cnt ($clog2(WIDTH) bits), registered done, and eq/lt/gt.
- IDLE with start=1 at an edge:
  - latch sa<=a, sb<=b, cnt<=WIDTH-1;
  - clear eq/lt/gt to 0;
  - go to RUN.
- IDLE with start=0: hold everything. done is 0 unless it is the completion pulse.
- RUN, each edge: apply sa[cnt], sb[cnt] to the compare cell.
  - Cell gt=1: gt<=1, done<=1, go to IDLE (early exit).
  - Cell lt=1: lt<=1, done<=1, go to IDLE (early exit).
  - Cell eq=1 and cnt==0: eq<=1, done<=1, go to IDLE.
  - Cell eq=1 and cnt>0: cnt<=cnt-1, stay in RUN.
- done is high for exactly one cycle after the deciding edge, then clears automatically.
- eq/lt/gt hold their result until the next accepted start clears them.
- After the first completion, exactly one of eq/lt/gt is high at any time outside RUN. All three are 0 during RUN.
- start while in RUN is ignored: no restart, no queueing.
- Changes to a/b after the accepting edge have no effect on the compare in progress.
- Operands are unsigned; no sign handling.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, eq, lt and gt all 0; sa, sb and cnt cleared. Outputs are 0 immediately, without waiting for a clock edge.
- Reset asserted during RUN aborts the compare. No done pulse is produced.
- Latency: let E0 be the edge that accepts start, and k = 1 + the number of leading (MSB-side) equal bit pairs, capped at WIDTH.
  - The deciding edge is E0+k.
  - done=1 and busy=0 in the cycle after E0+k.
  - Minimum k=1 (MSBs differ); maximum k=WIDTH (equal, or operands differ only in bit 0).
- busy=1 for the k cycles following E0, and is never high together with done.
- Back-to-back: start=1 during the done cycle is accepted, because the state is already IDLE.
  - eq/lt/gt clear on that edge.
  - done falls on that edge.
  - No idle bubble is required.
- Throughput: at most one compare every k+1 cycles.

## Test plan
- Reset: drive rst_n=0 mid-cycle with no clock edge → busy, done, eq, lt, gt all 0 immediately. Release, run 3 idle cycles → outputs remain 0.
- WIDTH=8, a=8'hA5, b=8'hA5, start for 1 cycle → busy high for 8 cycles, then done=1 with eq=1, lt=0, gt=0. Result holds after done falls.
- a=8'h80, b=8'h7F → done in the cycle after E0+1, with gt=1. a=8'h12, b=8'h13 → done after E0+8, with lt=1.
- Start held high through RUN, with a/b changed every cycle after acceptance → no restart. Result is for the originally captured operands (a=8'h40, b=8'h41 → lt=1 at E0+8).
- Back-to-back: assert start in the done cycle with a=8'h01, b=8'h00 → new compare accepted with no idle cycle, eq/lt/gt cleared, and gt=1 eight edges later.
- Reset mid-operation: a=8'h00, b=8'h00, assert rst_n=0 at E0+4 → no done pulse and all outputs 0. A fresh start after release completes normally with eq=1.
